// File: rtl/power_meter.sv
// Charge-and-release power meter: power ramps (saturating or ping-pong) while
// charge is held, and the value at release is reported as a one-cycle shot.
//
// state  | meaning
// IDLE   | meter cleared, waiting for charge
// CHARGE | prescaler running, power moves on each tick
// FIRE   | single cycle, shot_valid high, power cleared on exit
module power_meter #(
    parameter int WIDTH = 8,
    parameter int DIV   = 64,
    parameter int STEP  = 1,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             charge,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] power,
    output logic             full,
    output logic             shot_valid,
    output logic [WIDTH-1:0] shot_power
);

    localparam int PW = $clog2(DIV);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [PW-1:0]    PRE_TC = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CHARGE = 2'd1, FIRE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             dir_q, dir_d;       // 1 = counting down (ping-pong only)
    logic [WIDTH-1:0] power_q, power_d;
    logic [WIDTH-1:0] shot_q, shot_d;
    logic             full_q, full_d;

    logic             tick;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH-1:0] tick_val;
    logic             tick_dir;
    logic [WIDTH-1:0] load_clamped;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            dir_q   <= 1'b0;
            power_q <= '0;
            shot_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            dir_q   <= dir_d;
            power_q <= power_d;
            shot_q  <= shot_d;
            full_q  <= full_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (charge) state_d = CHARGE;
            CHARGE:  if (!charge) state_d = FIRE;
            FIRE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Tick arithmetic is done one bit wider so power+STEP can never wrap.
    always_comb begin
        tick     = (state_q == CHARGE) && (presc_q == PRE_TC);
        sum_up   = {1'b0, power_q} + STEP_X;
        tick_val = power_q;
        tick_dir = dir_q;
        if (!mode) begin
            tick_val = (sum_up >= MAX_X) ? MAX_V : sum_up[WIDTH-1:0];
        end else if (!dir_q) begin
            if (sum_up >= MAX_X) begin
                tick_val = MAX_V;
                tick_dir = 1'b1;
            end else begin
                tick_val = sum_up[WIDTH-1:0];
            end
        end else if ({1'b0, power_q} <= STEP_X) begin
            tick_val = '0;
            tick_dir = 1'b0;
        end else begin
            tick_val = power_q - STEP_X[WIDTH-1:0];
        end
        load_clamped = ({1'b0, load_value} >= MAX_X) ? MAX_V : load_value;
    end

    always_comb begin
        presc_d = presc_q;
        dir_d   = dir_q;
        power_d = power_q;
        shot_d  = shot_q;
        case (state_q)
            CHARGE: begin
                // Release freezes the current value; a same-cycle tick or load is dropped.
                if (!charge) begin
                    shot_d = power_q;
                end else if (load) begin
                    power_d = load_clamped;
                    presc_d = '0;
                end else if (tick) begin
                    power_d = tick_val;
                    dir_d   = tick_dir;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: begin
                power_d = '0;
                presc_d = '0;
                dir_d   = 1'b0;
            end
        endcase
        full_d = (power_d == MAX_V);
    end

    always_comb begin
        power      = power_q;
        full       = full_q;
        shot_valid = (state_q == FIRE);
        shot_power = shot_q;
    end

endmodule

// File: tb/tb_power_meter.sv
// Directed bench for power_meter with DIV=4, STEP=3, MAX=10, WIDTH=8.
module tb_power_meter;

    logic       clk;
    logic       rst;
    logic       charge;
    logic       mode;
    logic       load;
    logic [7:0] load_value;
    logic [7:0] power;
    logic       full;
    logic       shot_valid;
    logic [7:0] shot_power;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    power_meter #(.WIDTH(8), .DIV(4), .STEP(3), .MAX(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .charge     (charge),
        .mode       (mode),
        .load       (load),
        .load_value (load_value),
        .power      (power),
        .full       (full),
        .shot_valid (shot_valid),
        .shot_power (shot_power)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (shot_valid === 1'b1) pulses++;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int sat_pw[5];
        int sat_fl[5];
        int pp_pw[10];
        int pp_fl[10];
        sat_pw = '{3, 6, 9, 10, 10};
        sat_fl = '{0, 0, 0, 1, 1};
        pp_pw  = '{3, 6, 9, 10, 7, 4, 1, 0, 3, 6};
        pp_fl  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

        // reset held with charge high: nothing may advance
        rst = 1'b1; charge = 1'b1; mode = 1'b0; load = 1'b0; load_value = 8'd0;
        step(6);
        chk("rst_power", 32'(power), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_shot_valid", 32'(shot_valid), 0);
        chk("rst_shot_power", 32'(shot_power), 0);
        rst = 1'b0; charge = 1'b0;
        step(2);
        chk("idle_power", 32'(power), 0);

        // saturate mode
        charge = 1'b1; mode = 1'b0;
        step(1);
        for (int i = 0; i < 5; i++) begin
            step(3);
            if (i == 3) chk("sat_pre_full", 32'(full), 0);
            step(1);
            chk("sat_power", 32'(power), 32'(sat_pw[i]));
            chk("sat_full", 32'(full), 32'(sat_fl[i]));
        end
        charge = 1'b0;
        step(1);
        chk("sat_fire_valid", 32'(shot_valid), 1);
        chk("sat_fire_shot", 32'(shot_power), 10);
        step(1);
        chk("sat_exit_power", 32'(power), 0);
        chk("sat_exit_full", 32'(full), 0);
        chk("sat_exit_valid", 32'(shot_valid), 0);

        // ping-pong mode, then release at 6
        charge = 1'b1; mode = 1'b1;
        step(1);
        for (int i = 0; i < 10; i++) begin
            step(4);
            chk("pp_power", 32'(power), 32'(pp_pw[i]));
            chk("pp_full", 32'(full), 32'(pp_fl[i]));
        end
        charge = 1'b0;
        step(1);
        chk("rel_valid", 32'(shot_valid), 1);
        chk("rel_shot", 32'(shot_power), 6);
        step(1);
        chk("rel_power", 32'(power), 0);
        chk("rel_valid_low", 32'(shot_valid), 0);
        step(3);
        chk("rel_shot_hold", 32'(shot_power), 6);

        // load ignored in IDLE
        mode = 1'b0; load = 1'b1; load_value = 8'd5;
        step(1);
        chk("load_idle", 32'(power), 0);
        load = 1'b0;

        // load on the tick cycle wins and clamps; then mid-period load restarts prescaler
        charge = 1'b1;
        step(4);
        chk("load_pre", 32'(power), 0);
        load = 1'b1; load_value = 8'd200; mode = 1'b1;
        step(1);
        chk("load_clamp", 32'(power), 10);
        chk("load_full", 32'(full), 1);
        load = 1'b0;
        step(2);
        load = 1'b1; load_value = 8'd4;
        step(1);
        chk("load_mid", 32'(power), 4);
        chk("load_mid_full", 32'(full), 0);
        load = 1'b0;
        step(3);
        chk("load_presc_reset", 32'(power), 4);
        step(1);
        chk("load_tick", 32'(power), 7);
        step(4);
        chk("load_up_max", 32'(power), 10);
        step(4);
        chk("load_down", 32'(power), 7);
        charge = 1'b0;
        step(1);
        chk("load_rel_shot", 32'(shot_power), 7);
        step(1);

        // reset mid-charge at power 9, charge still held
        mode = 1'b0; charge = 1'b1;
        step(13);
        chk("rm_pre", 32'(power), 9);
        rst = 1'b1;
        step(1);
        chk("rm_power", 32'(power), 0);
        chk("rm_full", 32'(full), 0);
        chk("rm_valid", 32'(shot_valid), 0);
        rst = 1'b0;
        step(4);
        chk("rm_resume_pre", 32'(power), 0);
        step(1);
        chk("rm_resume", 32'(power), 3);

        // reset in the release cycle: no FIRE pulse, shot cleared
        rst = 1'b1; charge = 1'b0;
        step(1);
        chk("rf_valid", 32'(shot_valid), 0);
        chk("rf_shot", 32'(shot_power), 0);
        rst = 1'b0;
        step(2);

        // back-to-back charge 1->0->1
        charge = 1'b1;
        step(1);
        charge = 1'b0;
        step(1);
        chk("b2b_valid", 32'(shot_valid), 1);
        chk("b2b_shot", 32'(shot_power), 0);
        charge = 1'b1;
        step(1);
        chk("b2b_valid_low", 32'(shot_valid), 0);
        step(4);
        chk("b2b_late_entry", 32'(power), 0);
        step(1);
        chk("b2b_reentry", 32'(power), 3);
        charge = 1'b0;
        step(3);

        chk("pulse_count", 32'(pulses), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
